// File: rtl/uart_rx_ov.sv
// Oversampling UART receiver: synchronised rx, 3-sample majority per bit, false-start
// rejection, 5-8 data bits, optional/sticky parity, 1-2 stop bits, break detect with re-arm.
module uart_rx_ov #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       ne
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] SAMP0   = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] SAMP1   = CW'(OSR / 2);
  localparam logic [CW-1:0] DEC     = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2, BRK} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Upper data bits are always 0, so the reduction covers only received bits.
  function automatic logic parity_exp(input logic [7:0] d, input logic even, input logic stick);
    logic p;
    if (stick) begin
      p = ~even;
    end else if (even) begin
      p = ^d;
    end else begin
      p = ~^d;
    end
    return p;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rxs_s;
  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s, cnt_inc_s;
  logic [2:0]             bit_idx_r, bit_idx_s;
  logic [7:0]             data_r, data_s;
  logic                   s0_r, s0_s, s1_r, s1_s;
  logic                   ne_acc_r, ne_acc_s, pe_acc_r, pe_acc_s, par_bit_r, par_bit_s;
  logic                   push_r, push_s;
  logic [7:0]             dout_r, dout_s;
  logic                   pe_r, pe_s, fe_r, fe_s, bi_r, bi_s, ne_r, ne_s;
  logic                   maj_s, noisy_s, at_dec_s, at_wrap_s, last_bit_s, brk_s;

  assign rxs_s      = sync_r[SYNC_STAGES-1];
  assign maj_s      = maj3(s0_r, s1_r, rxs_s);
  assign noisy_s    = ~((s0_r == s1_r) && (s1_r == rxs_s));
  assign at_dec_s   = (cnt_r == DEC);
  assign at_wrap_s  = (cnt_r == CNT_MAX);
  assign cnt_inc_s  = at_wrap_s ? '0 : cnt_r + CW'(1);
  assign last_bit_s = (bit_idx_r >= (3'd4 + {1'b0, wls}));
  assign brk_s      = (data_r == 8'h00) & (~pen | ~par_bit_r) & ~maj_s;

  // Next-state and next-output logic for the receive FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    data_s    = data_r;
    s0_s      = s0_r;
    s1_s      = s1_r;
    ne_acc_s  = ne_acc_r;
    pe_acc_s  = pe_acc_r;
    par_bit_s = par_bit_r;
    push_s    = 1'b0;
    dout_s    = dout_r;
    pe_s      = pe_r;
    fe_s      = fe_r;
    bi_s      = bi_r;
    ne_s      = ne_r;
    if (baud_pulse) begin
      if (cnt_r == SAMP0) begin
        s0_s = rxs_s;
      end else if (cnt_r == SAMP1) begin
        s1_s = rxs_s;
      end else begin
        s0_s = s0_r;
      end
      case (state_r)
        IDLE: begin
          if (!rxs_s) begin
            state_s   = START;
            cnt_s     = '0;
            bit_idx_s = 3'd0;
            data_s    = 8'h00;
            ne_acc_s  = 1'b0;
            pe_acc_s  = 1'b0;
            par_bit_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          cnt_s = cnt_inc_s;
          if (at_dec_s) begin
            ne_acc_s = ne_acc_r | noisy_s;
            if (maj_s) begin
              state_s = IDLE;
              cnt_s   = '0;
            end else begin
              state_s = START;
            end
          end else if (at_wrap_s) begin
            state_s = DATA;
          end else begin
            state_s = START;
          end
        end
        DATA: begin
          cnt_s = cnt_inc_s;
          if (at_dec_s) begin
            data_s[bit_idx_r] = maj_s;
            ne_acc_s          = ne_acc_r | noisy_s;
          end else if (at_wrap_s) begin
            if (last_bit_s) begin
              bit_idx_s = 3'd0;
              state_s   = pen ? PARITY : STOP;
            end else begin
              bit_idx_s = bit_idx_r + 3'd1;
            end
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          cnt_s = cnt_inc_s;
          if (at_dec_s) begin
            par_bit_s = maj_s;
            pe_acc_s  = pe_acc_r | (maj_s != parity_exp(data_r, eps, sticky_parity));
            ne_acc_s  = ne_acc_r | noisy_s;
          end else if (at_wrap_s) begin
            state_s = STOP;
          end else begin
            state_s = PARITY;
          end
        end
        STOP: begin
          cnt_s = cnt_inc_s;
          if (at_dec_s) begin
            push_s = 1'b1;
            dout_s = data_r;
            pe_s   = pe_acc_r;
            fe_s   = ~maj_s;
            bi_s   = brk_s;
            ne_s   = ne_acc_r | noisy_s;
            // Leaving right after the decision lets a start edge inside the stop bit re-sync.
            if (brk_s) begin
              state_s = BRK;
              cnt_s   = '0;
            end else if (stb) begin
              state_s = STOP2;
            end else begin
              state_s = IDLE;
              cnt_s   = '0;
            end
          end else begin
            state_s = STOP;
          end
        end
        STOP2: begin
          cnt_s = cnt_inc_s;
          if (at_wrap_s) begin
            state_s = IDLE;
          end else begin
            state_s = STOP2;
          end
        end
        BRK: begin
          if (rxs_s) begin
            state_s = IDLE;
            cnt_s   = '0;
          end else begin
            state_s = BRK;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // rx synchroniser, idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
    end
  end

  // FSM state, accumulators and registered frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      data_r    <= 8'h00;
      s0_r      <= 1'b1;
      s1_r      <= 1'b1;
      ne_acc_r  <= 1'b0;
      pe_acc_r  <= 1'b0;
      par_bit_r <= 1'b0;
      push_r    <= 1'b0;
      dout_r    <= 8'h00;
      pe_r      <= 1'b0;
      fe_r      <= 1'b0;
      bi_r      <= 1'b0;
      ne_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      data_r    <= data_s;
      s0_r      <= s0_s;
      s1_r      <= s1_s;
      ne_acc_r  <= ne_acc_s;
      pe_acc_r  <= pe_acc_s;
      par_bit_r <= par_bit_s;
      push_r    <= push_s;
      dout_r    <= dout_s;
      pe_r      <= pe_s;
      fe_r      <= fe_s;
      bi_r      <= bi_s;
      ne_r      <= ne_s;
    end
  end

  assign push = push_r;
  assign dout = dout_r;
  assign pe   = pe_r;
  assign fe   = fe_r;
  assign bi   = bi_r;
  assign ne   = ne_r;

endmodule
